// File: rtl/morse_rx_decoder_pkg.sv
// Shared definitions for the morse receive decoder.
// Holds the FSM state type and the unit-timing constants. The transmit side
// uses the same unit constants, so both ends agree on what a dot, a dash and
// a letter gap are.
package morse_rx_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } state_t;

  localparam int DOT_UNITS  = 1;
  localparam int DASH_UNITS = 3;
  localparam int LETTER_GAP = 3;

  localparam logic [4:0] IDX_ERR = 5'd31;

endpackage

// File: rtl/morse_rx_decoder_if.sv
// Key-line and letter-output bundle for the morse receive decoder.
// Ports:
//   tick_en       one-clk strobe per morse unit
//   key_in        serial key line, 1 = mark, 0 = space
//   letter_valid  one-clk pulse when a letter completes
//   letter_idx    0..25 = A..Z, 31 on error
//   letter_err    qualifies letter_valid
//   busy          decoder is inside a letter
// master drives the key line, slave is the decoder.
interface morse_rx_decoder_if;
  logic       tick_en;
  logic       key_in;
  logic       letter_valid;
  logic [4:0] letter_idx;
  logic       letter_err;
  logic       busy;

  modport master (
    output tick_en, key_in,
    input  letter_valid, letter_idx, letter_err, busy
  );

  modport slave (
    input  tick_en, key_in,
    output letter_valid, letter_idx, letter_err, busy
  );
endinterface

// File: rtl/morse_letter_lut.sv
// Combinational symbol-to-letter table.
// Ports:
//   sym[3:0]  element k in bit k, 1 = dash, 0 = dot; bits at or above len are 0
//   len[2:0]  number of elements, 1..4 are valid
//   idx[4:0]  0..25 = A..Z, IDX_ERR when no letter matches
//   match     1 when {len, sym} names a letter
module morse_letter_lut
  import morse_rx_decoder_pkg::*;
(
  input  logic [3:0] sym,
  input  logic [2:0] len,
  output logic [4:0] idx,
  output logic       match
);

  always_comb begin
    idx = IDX_ERR;
    case ({len, sym})
      {3'd1, 4'b0000}: idx = 5'd4;   // E .
      {3'd1, 4'b0001}: idx = 5'd19;  // T -
      {3'd2, 4'b0000}: idx = 5'd8;   // I ..
      {3'd2, 4'b0010}: idx = 5'd0;   // A .-
      {3'd2, 4'b0001}: idx = 5'd13;  // N -.
      {3'd2, 4'b0011}: idx = 5'd12;  // M --
      {3'd3, 4'b0000}: idx = 5'd18;  // S ...
      {3'd3, 4'b0100}: idx = 5'd20;  // U ..-
      {3'd3, 4'b0010}: idx = 5'd17;  // R .-.
      {3'd3, 4'b0110}: idx = 5'd22;  // W .--
      {3'd3, 4'b0001}: idx = 5'd3;   // D -..
      {3'd3, 4'b0101}: idx = 5'd10;  // K -.-
      {3'd3, 4'b0011}: idx = 5'd6;   // G --.
      {3'd3, 4'b0111}: idx = 5'd14;  // O ---
      {3'd4, 4'b0000}: idx = 5'd7;   // H ....
      {3'd4, 4'b1000}: idx = 5'd21;  // V ...-
      {3'd4, 4'b0100}: idx = 5'd5;   // F ..-.
      {3'd4, 4'b0010}: idx = 5'd11;  // L .-..
      {3'd4, 4'b0110}: idx = 5'd15;  // P .--.
      {3'd4, 4'b1110}: idx = 5'd9;   // J .---
      {3'd4, 4'b0001}: idx = 5'd1;   // B -...
      {3'd4, 4'b1001}: idx = 5'd23;  // X -..-
      {3'd4, 4'b0101}: idx = 5'd2;   // C -.-.
      {3'd4, 4'b1101}: idx = 5'd24;  // Y -.--
      {3'd4, 4'b0011}: idx = 5'd25;  // Z --..
      {3'd4, 4'b1011}: idx = 5'd16;  // Q --.-
      default:         idx = IDX_ERR;
    endcase
    match = (idx != IDX_ERR);
  end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receive decoder.
// Samples the key line once per unit tick, times mark and space runs,
// classifies marks as dot (1 unit) or dash (3 units), collects up to MAX_ELEM
// elements and, on a 3-unit letter gap, pulses letter_valid for one clk with
// the letter index and an error flag.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of morse_rx_decoder_if (tick_en, key_in in;
//          letter_valid, letter_idx, letter_err, busy out)
module morse_rx_decoder
  import morse_rx_decoder_pkg::*;
#(
  parameter int MAX_ELEM = 4,
  parameter int RUN_W    = 3
) (
  input logic                clk,
  input logic                rst_n,
  morse_rx_decoder_if.slave  bus
);

  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_DOT  = RUN_W'(DOT_UNITS);
  localparam logic [RUN_W-1:0] RUN_DASH = RUN_W'(DASH_UNITS);
  localparam logic [RUN_W-1:0] RUN_GAP  = RUN_W'(LETTER_GAP);
  localparam logic [RUN_W-1:0] RUN_MAX  = '1;
  localparam logic [2:0]       ELEM_MAX = 3'(MAX_ELEM);

  state_t           state;
  logic [RUN_W-1:0] run;
  logic [2:0]       elem_cnt;
  logic [3:0]       sym;
  logic             err;

  logic             letter_valid;
  logic [4:0]       letter_idx;
  logic             letter_err;

  logic [4:0]       lut_idx;
  logic             lut_match;
  logic             emit_err;

  morse_letter_lut u_lut (
    .sym   (sym),
    .len   (elem_cnt),
    .idx   (lut_idx),
    .match (lut_match)
  );

  assign emit_err = err | ~lut_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      run          <= '0;
      elem_cnt     <= '0;
      sym          <= '0;
      err          <= 1'b0;
      letter_valid <= 1'b0;
      letter_idx   <= '0;
      letter_err   <= 1'b0;
    end else begin
      // The strobe is a single clk wide regardless of tick_en.
      letter_valid <= 1'b0;
      if (bus.tick_en) begin
        case (state)
          IDLE: begin
            if (bus.key_in) begin
              state    <= MARK;
              run      <= RUN_ONE;
              elem_cnt <= '0;
              sym      <= '0;
              err      <= 1'b0;
            end
          end
          MARK: begin
            if (bus.key_in) begin
              if (run != RUN_MAX) run <= run + 1'b1;
            end else begin
              if (run != RUN_DOT && run != RUN_DASH) err <= 1'b1;
              // A fifth element cannot fit: flag it and keep sym as it was.
              if (elem_cnt == ELEM_MAX) begin
                err <= 1'b1;
              end else begin
                sym[elem_cnt[1:0]] <= (run != RUN_DOT);
                elem_cnt           <= elem_cnt + 1'b1;
              end
              state <= SPACE;
              run   <= RUN_ONE;   // this tick is the first space unit
            end
          end
          SPACE: begin
            if (bus.key_in) begin
              state <= MARK;
              run   <= RUN_ONE;
            end else begin
              run <= run + 1'b1;
              if (run + 1'b1 == RUN_GAP) begin
                state        <= IDLE;
                letter_valid <= 1'b1;
                letter_err   <= emit_err;
                letter_idx   <= emit_err ? IDX_ERR : lut_idx;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.letter_valid = letter_valid;
  assign bus.letter_idx   = letter_idx;
  assign bus.letter_err   = letter_err;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder: drives unit ticks on the key line
// and checks letter strobes, indices, error flags and busy.
module tb_morse_rx_decoder;

  logic clk;
  logic rst_n;

  morse_rx_decoder_if bus ();

  morse_rx_decoder #(.MAX_ELEM(4), .RUN_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Every strobe seen on a falling edge is logged here.
  int         pulses = 0;
  logic [4:0] idx_log [32];
  logic       err_log [32];

  always @(negedge clk) begin
    if (bus.letter_valid === 1'b1) begin
      if (pulses < 32) begin
        idx_log[pulses] = bus.letter_idx;
        err_log[pulses] = bus.letter_err;
      end
      pulses = pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic k);
    @(negedge clk);
    bus.key_in  = k;
    bus.tick_en = 1'b1;
    @(negedge clk);
    bus.tick_en = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i] == "1");
  endtask

  // Five non-tick clks with a toggling key line before each tick.
  task automatic send_str_gated(input string s);
    for (int i = 0; i < s.len(); i++) begin
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        bus.tick_en = 1'b0;
        bus.key_in  = 1'($urandom_range(0, 1));
      end
      send(s[i] == "1");
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // One letter that must give exactly one strobe with the given result.
  task automatic letter(input string tag, input string s, input int exp_idx, input int exp_err);
    int p0;
    p0 = pulses;
    send_str(s);
    settle();
    check({tag, "_pulses"}, pulses, p0 + 1);
    check({tag, "_idx"}, idx_log[p0], exp_idx);
    check({tag, "_err"}, err_log[p0], exp_err);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int p0;
    rst_n       = 1'b0;
    bus.tick_en = 1'b0;
    bus.key_in  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", bus.letter_valid, 0);
    check("rst_idx",   bus.letter_idx,   0);
    check("rst_err",   bus.letter_err,   0);
    check("rst_busy",  bus.busy,         0);
    @(negedge clk);
    rst_n = 1'b1;

    // A, then a word gap that must stay silent.
    letter("A", "10111000", 0, 0);
    p0 = pulses;
    send_str("0000");
    settle();
    check("wordgap_pulses", pulses, p0);

    // A with a 2-unit intra-letter gap; busy high inside the letter.
    p0 = pulses;
    send_str("1");
    settle();
    check("busy_mid", bus.busy, 1);
    send_str("00111000");
    settle();
    check("A2_pulses", pulses, p0 + 1);
    check("A2_idx", idx_log[p0], 0);

    // E then T back to back.
    p0 = pulses;
    send_str("1000111000");
    settle();
    check("ET_pulses", pulses, p0 + 2);
    check("E_idx", idx_log[p0], 4);
    check("E_err", err_log[p0], 0);
    check("T_idx", idx_log[p0 + 1], 19);
    check("T_err", err_log[p0 + 1], 0);

    letter("bad_mark", "11000", 31, 1);
    letter("overflow", "101010101000", 31, 1);
    letter("nonletter", "10101110111000", 31, 1);
    letter("sat_mark", "111111111000", 31, 1);

    // Q (--.-) with idle clks between every tick.
    p0 = pulses;
    send_str_gated("1110111010111000");
    settle();
    check("Q_pulses", pulses, p0 + 1);
    check("Q_idx", idx_log[p0], 16);
    check("Q_err", err_log[p0], 0);
    repeat (4) @(negedge clk);
    #1;
    check("Q_hold_idx", bus.letter_idx, 16);

    // Reset in the dash of K.
    p0 = pulses;
    send_str("11");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.letter_valid, 0);
    check("midrst_idx",   bus.letter_idx,   0);
    check("midrst_err",   bus.letter_err,   0);
    check("midrst_busy",  bus.busy,         0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_str("000");
    settle();
    check("midrst_nopulse", pulses, p0);
    letter("S", "10101000", 18, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
